// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by pipeline_hazard_ctrl and load_use_detect.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WAIT_CNT_W = 8;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    RUN       = 1'b0,
    DMEM_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination
// feeds either source of the instruction in ID.
import pipe_ctrl_pkg::*;

module load_use_detect (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_read,
  output logic                  hazard
);

  logic rd_live;

  // x0 never carries a dependency, so rd==0 is never a hazard
  always_comb begin
    rd_live = (rd != '0);
    hazard  = mem_read && rd_live &&
              ((rd == rs1) || (rd == rs2));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush control for the 5-stage pipeline: memory wait,
// mispredict flush, load-use bubble. PIPE_CTRL_PERF_EN adds counters.
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic                  ID_EX_mem_read,
  input  logic                  ex_mispredict,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_hold,
  output logic                  EX_MEM_stall,
  output logic                  IF_ID_hold,
  output logic                  ID_EX_bubble,
  output logic                  EX_flush,
  output logic                  mem_err,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);

  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
    WAIT_CNT_W'(TIMEOUT - 1);

  ctrl_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  err_set;
  logic                  lu_hazard;
  logic                  stall_c, hold_c, ifid_c;
  logic                  bubble_c, flush_c;

  load_use_detect u_lud (
    .rs1      (IF_ID_rs1),
    .rs2      (IF_ID_rs2),
    .rd       (ID_EX_rd),
    .mem_read (ID_EX_mem_read),
    .hazard   (lu_hazard)
  );

  // Next state and raw controls; memory stall wins, then flush, then load-use
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    err_set  = 1'b0;
    stall_c  = 1'b0;
    hold_c   = 1'b0;
    ifid_c   = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
          state_d = DMEM_WAIT;
          cnt_d   = '0;
          pend_d  = pend_q || ex_mispredict;
        end else if (ex_mispredict || pend_q) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          pend_d   = 1'b0;
        end else if (lu_hazard) begin
          hold_c   = 1'b1;
          ifid_c   = 1'b1;
          bubble_c = 1'b1;
        end
      end
      DMEM_WAIT: begin
        pend_d = pend_q || ex_mispredict;
        if (dmem_ready) begin
          state_d = RUN;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = RUN;
          err_set = 1'b1;
        end else begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Controls forced low while reset is held
  always_comb begin
    pc_hold      = hold_c   && !reset;
    EX_MEM_stall = stall_c  && !reset;
    IF_ID_hold   = ifid_c   && !reset;
    ID_EX_bubble = bubble_c && !reset;
    EX_flush     = flush_c  && !reset;
  end

  // FSM, wait counter, deferred flush and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (err_set) mem_err <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Cycle counts of PC hold and flush; wrap naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_hold)  stall_cycles <= stall_cycles + 32'd1;
      if (EX_flush) flush_count  <= flush_count + 32'd1;
    end
  end
`else
  // Counters not built
  always_comb begin
    stall_cycles = '0;
    flush_count  = '0;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (default and TIMEOUT=4).
// Counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       mem_read, mispredict, req, ready;

  logic        pc_hold, stall, ifid, bubble, flush, err;
  logic [31:0] scyc, fcnt;
  logic        pc_hold4, stall4, ifid4, bubble4, flush4, err4;
  logic [31:0] scyc4, fcnt4;

  int errors = 0;
  int checks = 0;

  wire [4:0] outs  = {pc_hold, stall, ifid, bubble, flush};
  wire [4:0] outs4 = {pc_hold4, stall4, ifid4, bubble4, flush4};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .ID_EX_rd(rd),
    .ID_EX_mem_read(mem_read), .ex_mispredict(mispredict),
    .dmem_req(req), .dmem_ready(ready),
    .pc_hold(pc_hold), .EX_MEM_stall(stall),
    .IF_ID_hold(ifid), .ID_EX_bubble(bubble),
    .EX_flush(flush), .mem_err(err),
    .stall_cycles(scyc), .flush_count(fcnt)
  );

  pipeline_hazard_ctrl #(.TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .ID_EX_rd(rd),
    .ID_EX_mem_read(mem_read), .ex_mispredict(mispredict),
    .dmem_req(req), .dmem_ready(ready),
    .pc_hold(pc_hold4), .EX_MEM_stall(stall4),
    .IF_ID_hold(ifid4), .ID_EX_bubble(bubble4),
    .EX_flush(flush4), .mem_err(err4),
    .stall_cycles(scyc4), .flush_count(fcnt4)
  );

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; mem_read = 0;
    mispredict = 0; req = 0; ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mispredict = 1; mem_read = 1; rd = 3; rs1 = 3;
    req = 1; ready = 0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 00000", outs);
    end
    checks++;
    if ({err, scyc, fcnt} !== 65'b0) begin
      errors++;
      $display("FAIL reset_state: err=%b sc=%0d fc=%0d want 0",
               err, scyc, fcnt);
    end
    next_cycle();
    idle();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    logic [4:0] exp [4] = '{5'b10110, 5'b00000, 5'b10110, 5'b00000};
    logic [4:0] rdv [4] = '{5'd5, 5'd0, 5'd7, 5'd7};
    logic [4:0] r1v [4] = '{5'd1, 5'd0, 5'd7, 5'd7};
    logic [4:0] r2v [4] = '{5'd5, 5'd0, 5'd2, 5'd2};
    logic       mrv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd = rdv[i]; rs1 = r1v[i]; rs2 = r2v[i]; mem_read = mrv[i];
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b want %b", i, outs, exp[i]);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_mem_wait();
    int n = 0;
    do_reset();
    req = 1; ready = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) ready = 1;
      if (i == 5) begin req = 0; ready = 0; end
      @(negedge clk);
      if (stall) n++;
      checks++;
      if (outs !== ((i < 4) ? 5'b11000 : 5'b00000)) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b", i, outs);
      end
      next_cycle();
    end
    checks++;
    if (n !== 4 || err !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_len: got %0d err=%b want 4 err=0", n, err);
    end
    idle();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 1; ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) req = 0;
      @(negedge clk);
      checks++;
      if ({stall4, pc_hold4, err4} !== {(i < 4), (i < 4), 1'b0}) begin
        errors++;
        $display("FAIL timeout[%0d]: st=%b ph=%b err=%b",
                 i, stall4, pc_hold4, err4);
      end
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (err4 !== 1'b1 || stall4 !== 1'b0) begin
        errors++;
        $display("FAIL timeout_err[%0d]: err=%b st=%b want 1 0",
                 i, err4, stall4);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_deferred_flush();
    logic [4:0] exp [7] = '{5'b11000, 5'b11000, 5'b11000, 5'b11000,
                            5'b00000, 5'b00011, 5'b00000};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req = (i < 5); ready = (i == 4);
      mispredict = (i == 2);
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL defer_flush[%0d]: got %b want %b", i, outs, exp[i]);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_priority();
    do_reset();
    mispredict = 1; mem_read = 1; rd = 4; rs1 = 4;
    @(negedge clk);
    checks++;
    if (outs !== 5'b00011) begin
      errors++;
      $display("FAIL prio_lu: got %b want 00011", outs);
    end
    next_cycle();
    idle();
    mispredict = 1; req = 1; ready = 0;
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000) begin
      errors++;
      $display("FAIL prio_mem: got %b want 11000", outs);
    end
    next_cycle();
    mispredict = 0; ready = 1;
    @(negedge clk);
    checks++;
    if (outs !== 5'b00000) begin
      errors++;
      $display("FAIL prio_exit: got %b want 00000", outs);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (outs !== 5'b00011) begin
      errors++;
      $display("FAIL prio_late: got %b want 00011", outs);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req = 1; ready = 0;
    next_cycle();
    mispredict = 1;
    #2 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL rst_wait_held: got %b want 00000", outs);
    end
    next_cycle();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 5'b0) begin
        errors++;
        $display("FAIL rst_wait_after[%0d]: got %b want 00000", i, outs);
      end
      next_cycle();
    end
  endtask

  task automatic test_perf();
    logic [31:0] es, ef;
`ifdef PIPE_CTRL_PERF_EN
    es = 32'd10; ef = 32'd2;
`else
    es = 32'd0; ef = 32'd0;
`endif
    do_reset();
    req = 1; ready = 0;
    for (int i = 0; i < 9; i++) next_cycle();
    ready = 1;
    next_cycle();
    idle();
    mem_read = 1; rd = 9; rs1 = 9;
    next_cycle();
    idle();
    mispredict = 1;
    next_cycle();
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (scyc !== es) begin
      errors++;
      $display("FAIL perf_stall: got %0d want %0d", scyc, es);
    end
    checks++;
    if (fcnt !== ef) begin
      errors++;
      $display("FAIL perf_flush: got %0d want %0d", fcnt, ef);
    end
    next_cycle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #1;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_deferred_flush();
    test_priority();
    test_reset_mid_wait();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
